// File: rtl/score_bcd_converter.sv
// Sequential double-dabble binary-to-BCD encoder for the score display.
// Converts one bit per clock and updates the packed BCD output word in a single step.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; BCD_bits holds the last completed result
// ST_SHIFT| one add-3/shift iteration per clock, BIN_WIDTH iterations
// ST_DONE | copy scratch into BCD_bits and pulse done
module score_bcd_converter #(
    parameter int BIN_WIDTH = 27,
    parameter int DIGITS    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    binary_in,
    output logic [4*DIGITS-1:0]     BCD_bits,
    output logic                    busy,
    output logic                    done
);

    localparam int          BCD_W   = 4 * DIGITS;
    localparam int          CNT_W   = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] MAX_VAL = (64'd10 ** DIGITS) - 64'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t                 state_q,   state_d;
    logic [BCD_W-1:0]       scratch_q, scratch_d;
    logic [BIN_WIDTH-1:0]   operand_q, operand_d;
    logic [CNT_W-1:0]       count_q,   count_d;
    logic [BCD_W-1:0]       bcd_q,     bcd_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;

    logic [BCD_W-1:0]       scratch_adj;
    logic [BIN_WIDTH-1:0]   operand_sat;

    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign scratch_adj = add3_digits(scratch_q);

    // Scores beyond the display range clamp to all nines.
    assign operand_sat = ({{(64-BIN_WIDTH){1'b0}}, binary_in} > MAX_VAL)
                         ? BIN_WIDTH'(MAX_VAL) : binary_in;

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        operand_d = operand_q;
        count_d   = count_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    operand_d = operand_sat;
                    scratch_d = '0;
                    count_d   = CNT_W'(BIN_WIDTH);
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {scratch_d, operand_d} = {scratch_adj, operand_q} << 1;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            scratch_q <= '0;
            operand_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            operand_q <= operand_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign BCD_bits = bcd_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
